alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational integer ALU between two requesters: port 0 = execute stage, port 1 = branch/address unit.
- Arbitrates round-robin with valid/ready handshakes and drives the ALU operand and function inputs.
- Captures the ALU result and flags into one registered response channel, tagged with the winning port and the requester's tag.
- Throughput is one operation per cycle. Latency is 1 cycle from accept to response valid.

Parameters:
- TAG_W, 4, width of the requester-supplied tag returned with each result.
- CNT_W, 16, width of the per-port grant counters. The counters saturate.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 has an operation.
- req0_ready  out  1  port 0 operation accepted this cycle.
- req0_a  in  32  port 0 operand a.
- req0_b  in  32  port 0 operand b.
- req0_func3  in  3  port 0 func3.
- req0_func7  in  7  port 0 func7.
- req0_tag  in  TAG_W  port 0 tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_func3, req1_func7, req1_tag: same as port 0, for port 1.
- alu_a  out  32  operand a to the ALU.
- alu_b  out  32  operand b to the ALU.
- alu_func3  out  3  func3 to the ALU.
- alu_func7  out  7  func7 to the ALU.
- alu_r  in  32  ALU result (combinational from alu_*).
- alu_flags  in  3  ALU flags; bit0 = zero, bit1 = negative, bit2 = reserved, passed through untouched.
- resp_valid  out  1  a response is held.
- resp_ready  in  1  consumer takes the response.
- resp_id  out  1  port that issued the operation.
- resp_tag  out  TAG_W  tag of that operation.
- resp_r  out  32  registered result.
- resp_flags  out  3  registered flags.
- grant_cnt0  out  CNT_W  number of operations accepted from port 0.
- grant_cnt1  out  CNT_W  number of operations accepted from port 1.

Behaviour:
- Reset values: resp_valid=0, resp_id=0, resp_tag=0, resp_r=0, resp_flags=0, grant_cnt0=0, grant_cnt1=0, last_grant=1 (so port 0 wins the first tie).
- Reset overrides everything; an operation accepted in the reset cycle is dropped.
- can_accept = !resp_valid || resp_ready (the output register is empty or draining this cycle).
- Grant (combinational):
  - Only one port valid: that port wins.
  - Both valid: the port != last_grant wins.
  - req*_ready = can_accept && (port is the winner).
  - req*_ready never depends on that port's own req*_valid beyond arbitration; no combinational path from resp_ready to alu_*.
- ALU drive: alu_* carry the winner's fields. With no valid requester, alu_* carry port 0's fields (don't-care, but deterministic).
- Accept edge (some req*_valid && can_accept):
  - resp_valid<=1.
  - resp_id<=winner, resp_tag<=winner tag.
  - resp_r<=alu_r, resp_flags<=alu_flags.
  - last_grant<=winner.
  - Winner's grant count increments, saturating at all-ones.
- Drain without accept (resp_ready && resp_valid && no request): resp_valid<=0; data registers hold their old values.
- Stall (resp_valid && !resp_ready): all resp_* hold, both req*_ready=0, last_grant holds.
- Back-to-back: accept and drain in the same cycle → the new result replaces the old one; resp_valid stays 1.
- Requesters must hold their fields stable while valid && !ready; the block does not buffer requests.
- Fairness: under continuous contention, grants alternate 0,1,0,1… and no port waits more than one accepted operation.
- States, implicit in resp_valid:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on drain without accept.
  - FULL → FULL on stall, or on drain with accept.

Test Plan:
- Reset, then port 0 only: a=5, b=3, func3=0, func7=0, tag=2 → req0_ready=1 that cycle; next cycle resp_valid=1, resp_r=8, resp_id=0, resp_tag=2, resp_flags[0]=0.
- Both ports valid every cycle, resp_ready=1 → grant order 0,1,0,1. Port 1 sub with a=7, b=7, func7=0x20 → resp_r=0, flags[0]=1. Counters reach 2/2 after 4 cycles.
- resp_ready=0 for 3 cycles with both ports valid → resp_* frozen, both readys=0. On release, the pending winner is the port != last_grant.
- Accept and drain in the same cycle across 8 consecutive ops from port 1 → 8 responses on consecutive cycles, no bubble, tags 0..7 in order.
- rst asserted while resp_valid=1 and both requests valid → next cycle resp_valid=0 and counters 0. The first grant after reset goes to port 0.
- Force grant_cnt0 to saturate (CNT_W=2 build): 5 port-0 ops → grant_cnt0 holds 3.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters,
// with a single registered response channel and saturating per-port grant counters.
module alu_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_func3,
  input  logic [6:0]       req0_func7,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_func3,
  input  logic [6:0]       req1_func7,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_func3,
  output logic [6:0]       alu_func7,
  input  logic [31:0]      alu_r,
  input  logic [2:0]       alu_flags,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_r,
  output logic [2:0]       resp_flags,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);
  logic             last_q, last_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic [31:0]      resp_r_q, resp_r_d;
  logic [2:0]       resp_flags_q, resp_flags_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             win, can_accept, accept;
  // winner is independent of resp_ready, so alu_* never sees the consumer handshake
  always_comb begin
    win          = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    can_accept   = ~resp_valid_q | resp_ready;
    accept       = (req0_valid | req1_valid) & can_accept;
    req0_ready   = accept & ~win;
    req1_ready   = accept & win;
    alu_a        = win ? req1_a : req0_a;
    alu_b        = win ? req1_b : req0_b;
    alu_func3    = win ? req1_func3 : req0_func3;
    alu_func7    = win ? req1_func7 : req0_func7;
    resp_valid_d = accept | (resp_valid_q & ~resp_ready);
    resp_id_d    = accept ? win : resp_id_q;
    resp_tag_d   = accept ? (win ? req1_tag : req0_tag) : resp_tag_q;
    resp_r_d     = accept ? alu_r : resp_r_q;
    resp_flags_d = accept ? alu_flags : resp_flags_q;
    last_d       = accept ? win : last_q;
    cnt0_d       = (req0_ready && cnt0_q != '1) ? cnt0_q + 1'b1 : cnt0_q;
    cnt1_d       = (req1_ready && cnt1_q != '1) ? cnt1_q + 1'b1 : cnt1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_tag_q   <= '0;
      resp_r_q     <= '0;
      resp_flags_q <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      last_q       <= last_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_tag_q   <= resp_tag_d;
      resp_r_q     <= resp_r_d;
      resp_flags_q <= resp_flags_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_tag   = resp_tag_q;
  assign resp_r     = resp_r_q;
  assign resp_flags = resp_flags_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_func3, req1_func3;
  logic [6:0] req0_func7, req1_func7;
  logic [3:0] req0_tag, req1_tag;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [2:0] alu_func3, alu_flags;
  logic [6:0] alu_func7;
  logic resp_valid, resp_ready, resp_id;
  logic [3:0] resp_tag;
  logic [31:0] resp_r;
  logic [2:0] resp_flags;
  logic [15:0] grant_cnt0, grant_cnt1;
  logic s_r0, s_r1, s_valid, s_id;
  logic [31:0] s_a, s_b, s_alu_r, s_r;
  logic [2:0] s_f3, s_alu_flags, s_flags;
  logic [6:0] s_f7;
  logic [3:0] s_tag;
  logic [1:0] s_cnt0, s_cnt1;
  int tests = 0, fails = 0;
  int m_last, m_cnt0, m_cnt1, m_s0, m_s1;
  logic m_valid, m_id;
  logic [3:0] m_tag;
  logic [31:0] m_r;
  logic [2:0] m_flags;

  always #5 clk = ~clk;

  function automatic logic [34:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [2:0] f3, logic [6:0] f7);
    logic [31:0] r;
    case (f3)
      3'd0: r = f7[5] ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = {31'b0, $signed(a) < $signed(b)};
      3'd3: r = {31'b0, a < b};
      3'd4: r = a ^ b;
      3'd5: r = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return {^r, r[31], r == 32'd0, r};
  endfunction

  always_comb {alu_flags, alu_r} = alu_ref(alu_a, alu_b, alu_func3, alu_func7);
  always_comb {s_alu_flags, s_alu_r} = alu_ref(s_a, s_b, s_f3, s_f7);

  alu_arbiter #(.TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_func3(req0_func3), .req0_func7(req0_func7), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_func3(req1_func3), .req1_func7(req1_func7), .req1_tag(req1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func3(alu_func3), .alu_func7(alu_func7),
    .alu_r(alu_r), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_tag(resp_tag),
    .resp_r(resp_r), .resp_flags(resp_flags), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  // narrow-counter instance shares all stimulus to exercise saturation quickly
  alu_arbiter #(.TAG_W(4), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(s_r0), .req0_a(req0_a), .req0_b(req0_b),
    .req0_func3(req0_func3), .req0_func7(req0_func7), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(s_r1), .req1_a(req1_a), .req1_b(req1_b),
    .req1_func3(req1_func3), .req1_func7(req1_func7), .req1_tag(req1_tag),
    .alu_a(s_a), .alu_b(s_b), .alu_func3(s_f3), .alu_func7(s_f7),
    .alu_r(s_alu_r), .alu_flags(s_alu_flags),
    .resp_valid(s_valid), .resp_ready(resp_ready), .resp_id(s_id), .resp_tag(s_tag),
    .resp_r(s_r), .resp_flags(s_flags), .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
  );

  function automatic int pick();
    if (req0_valid && req1_valid) return 1 - m_last;
    return req1_valid ? 1 : 0;
  endfunction

  function automatic bit exp_ready(int p);
    return (req0_valid || req1_valid) && (!m_valid || resp_ready) && pick() == p;
  endfunction

  task automatic tick();
    int w;
    bit acc;
    logic [34:0] res;
    w = pick();
    acc = (req0_valid || req1_valid) && (!m_valid || resp_ready);
    if (rst) begin
      m_valid = 0; m_id = 0; m_tag = 0; m_r = 0; m_flags = 0; m_last = 1;
      m_cnt0 = 0; m_cnt1 = 0; m_s0 = 0; m_s1 = 0;
    end else if (acc) begin
      res = w == 1 ? alu_ref(req1_a, req1_b, req1_func3, req1_func7) : alu_ref(req0_a, req0_b, req0_func3, req0_func7);
      m_valid = 1; m_id = w[0]; m_tag = w == 1 ? req1_tag : req0_tag;
      m_r = res[31:0]; m_flags = res[34:32]; m_last = w;
      if (w == 0) begin
        m_cnt0 = m_cnt0 < 65535 ? m_cnt0 + 1 : m_cnt0;
        m_s0 = m_s0 < 3 ? m_s0 + 1 : m_s0;
      end else begin
        m_cnt1 = m_cnt1 < 65535 ? m_cnt1 + 1 : m_cnt1;
        m_s1 = m_s1 < 3 ? m_s1 + 1 : m_s1;
      end
    end else if (resp_ready) m_valid = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req0_valid = 0; req1_valid = 0; resp_ready = 0;
    req0_a = 0; req0_b = 0; req0_func3 = 0; req0_func7 = 0; req0_tag = 0;
    req1_a = 0; req1_b = 0; req1_func3 = 0; req1_func7 = 0; req1_tag = 0;
    tick(); tick();
    rst = 0;
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
    tests++; if ({resp_id, resp_tag, resp_flags} !== 8'd0) begin fails++; $display("FAIL reset_id_tag_flags got %b/%h/%b exp 0", resp_id, resp_tag, resp_flags); end
    tests++; if (resp_r !== 32'd0) begin fails++; $display("FAIL reset_r got %h exp 0", resp_r); end
    tests++; if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", grant_cnt0, grant_cnt1); end
  endtask

  task automatic test_port0_only();
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_func3 = 0; req0_func7 = 0; req0_tag = 2;
    resp_ready = 1;
    #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin fails++; $display("FAIL p0_ready got %b%b exp 10", req0_ready, req1_ready); end
    tick();
    tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL p0_valid got %b exp 1", resp_valid); end
    tests++; if (resp_r !== 32'd8) begin fails++; $display("FAIL p0_r got %0d exp 8", resp_r); end
    tests++; if (resp_id !== 1'b0 || resp_tag !== 4'd2) begin fails++; $display("FAIL p0_id_tag got %b/%0d exp 0/2", resp_id, resp_tag); end
    tests++; if (resp_flags[0] !== 1'b0) begin fails++; $display("FAIL p0_zero got %b exp 0", resp_flags[0]); end
    req0_valid = 0;
    #1;
    tick();
    tests++; if (resp_valid !== 1'b0 || resp_r !== 32'd8) begin fails++; $display("FAIL p0_drain got %b/%0d exp 0/8", resp_valid, resp_r); end
  endtask

  task automatic test_contention();
    logic [31:0] a0, b0;
    rst = 1; tick(); rst = 0;
    a0 = $urandom_range(0, 100000); b0 = $urandom_range(0, 100000);
    req0_valid = 1; req0_a = a0; req0_b = b0; req0_func3 = 0; req0_func7 = 0; req0_tag = 4'd5;
    req1_valid = 1; req1_a = 7; req1_b = 7; req1_func3 = 0; req1_func7 = 7'h20; req1_tag = 4'd9;
    resp_ready = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin fails++; $display("FAIL rr_ready[%0d] got %b%b", i, req0_ready, req1_ready); end
      tick();
      tests++; if (resp_id !== 1'((i % 2))) begin fails++; $display("FAIL rr_id[%0d] got %b exp %0d", i, resp_id, i % 2); end
      if (i % 2 == 1) begin
        tests++; if (resp_r !== 32'd0 || resp_flags[0] !== 1'b1 || resp_tag !== 4'd9) begin fails++; $display("FAIL rr_sub[%0d] got r=%0d z=%b tag=%0d exp 0/1/9", i, resp_r, resp_flags[0], resp_tag); end
      end else begin
        tests++; if (resp_r !== a0 + b0 || resp_tag !== 4'd5) begin fails++; $display("FAIL rr_add[%0d] got r=%0d tag=%0d exp %0d/5", i, resp_r, resp_tag, a0 + b0); end
      end
    end
    tests++; if (grant_cnt0 !== 16'd2 || grant_cnt1 !== 16'd2) begin fails++; $display("FAIL rr_cnt got %0d/%0d exp 2/2", grant_cnt0, grant_cnt1); end
  endtask

  task automatic test_stall();
    resp_ready = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin fails++; $display("FAIL stall_ready[%0d] got %b%b exp 00", i, req0_ready, req1_ready); end
      tick();
      tests++; if (resp_valid !== 1'b1 || resp_id !== m_id || resp_tag !== m_tag || resp_r !== m_r || resp_flags !== m_flags) begin
        fails++; $display("FAIL stall_hold[%0d] got %b/%b/%h/%h/%b exp 1/%b/%h/%h/%b", i, resp_valid, resp_id, resp_tag, resp_r, resp_flags, m_id, m_tag, m_r, m_flags);
      end
    end
    resp_ready = 1;
    #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin fails++; $display("FAIL stall_release got %b%b exp 10", req0_ready, req1_ready); end
    tick();
    tests++; if (resp_id !== 1'b0 || grant_cnt0 !== 16'd3) begin fails++; $display("FAIL stall_after got id=%b cnt0=%0d exp 0/3", resp_id, grant_cnt0); end
  endtask

  task automatic test_back_to_back();
    req0_valid = 0; req1_valid = 1; resp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      req1_tag = 4'(i); req1_a = $urandom; req1_b = $urandom;
      req1_func3 = 3'($urandom_range(0, 7)); req1_func7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      #1;
      tests++; if (req1_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, req1_ready); end
      tick();
      tests++; if (resp_valid !== 1'b1 || resp_tag !== 4'(i) || resp_id !== 1'b1 || resp_r !== m_r || resp_flags !== m_flags) begin
        fails++; $display("FAIL b2b_resp[%0d] got v=%b tag=%0d id=%b r=%h f=%b exp 1/%0d/1/%h/%b", i, resp_valid, resp_tag, resp_id, resp_r, resp_flags, i, m_r, m_flags);
      end
    end
  endtask

  task automatic test_reset_midflight();
    req0_valid = 1; req1_valid = 1; resp_ready = 0;
    #1;
    tick();
    rst = 1;
    #1;
    tick();
    rst = 0;
    tests++; if (resp_valid !== 1'b0 || grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin fails++; $display("FAIL midrst got v=%b cnt=%0d/%0d exp 0/0/0", resp_valid, grant_cnt0, grant_cnt1); end
    #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin fails++; $display("FAIL midrst_ready got %b%b exp 10", req0_ready, req1_ready); end
    tick();
    tests++; if (resp_id !== 1'b0 || resp_valid !== 1'b1) begin fails++; $display("FAIL midrst_first got id=%b v=%b exp 0/1", resp_id, resp_valid); end
  endtask

  task automatic test_saturate();
    rst = 1; req0_valid = 0; req1_valid = 0; tick(); rst = 0;
    req0_valid = 1; resp_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    tests++; if (s_cnt0 !== 2'd3 || s_cnt1 !== 2'd0) begin fails++; $display("FAIL sat_small got %0d/%0d exp 3/0", s_cnt0, s_cnt1); end
    tests++; if (grant_cnt0 !== 16'd5) begin fails++; $display("FAIL sat_wide got %0d exp 5", grant_cnt0); end
  endtask

  task automatic test_random();
    logic r0, r1;
    logic [31:0] ea;
    r0 = 0; r1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(req0_valid && !r0)) begin
        req0_valid = 1'($urandom_range(0, 1)); req0_a = $urandom; req0_b = $urandom;
        req0_func3 = 3'($urandom_range(0, 7)); req0_func7 = $urandom_range(0, 1) ? 7'h20 : 7'h00; req0_tag = 4'($urandom);
      end
      if (!(req1_valid && !r1)) begin
        req1_valid = 1'($urandom_range(0, 1)); req1_a = $urandom; req1_b = $urandom;
        req1_func3 = 3'($urandom_range(0, 7)); req1_func7 = $urandom_range(0, 1) ? 7'h20 : 7'h00; req1_tag = 4'($urandom);
      end
      resp_ready = $urandom_range(0, 9) < 7;
      rst = $urandom_range(0, 99) == 0;
      #1;
      ea = pick() == 1 ? req1_a : req0_a;
      tests++; if (alu_a !== ea) begin fails++; $display("FAIL rnd_alu_a[%0d] got %h exp %h", i, alu_a, ea); end
      if (req0_valid || req1_valid) begin
        tests++; if (req0_ready !== exp_ready(0) || req1_ready !== exp_ready(1)) begin fails++; $display("FAIL rnd_ready[%0d] got %b%b exp %b%b", i, req0_ready, req1_ready, exp_ready(0), exp_ready(1)); end
      end
      r0 = req0_ready; r1 = req1_ready;
      tick();
      tests++; if (resp_valid !== m_valid || resp_id !== m_id || resp_tag !== m_tag || resp_r !== m_r || resp_flags !== m_flags) begin
        fails++; $display("FAIL rnd_resp[%0d] got %b/%b/%h/%h/%b exp %b/%b/%h/%h/%b", i, resp_valid, resp_id, resp_tag, resp_r, resp_flags, m_valid, m_id, m_tag, m_r, m_flags);
      end
      tests++; if (grant_cnt0 !== 16'(m_cnt0) || grant_cnt1 !== 16'(m_cnt1) || s_cnt0 !== 2'(m_s0) || s_cnt1 !== 2'(m_s1)) begin
        fails++; $display("FAIL rnd_cnt[%0d] got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", i, grant_cnt0, grant_cnt1, s_cnt0, s_cnt1, m_cnt0, m_cnt1, m_s0, m_s1);
      end
    end
    rst = 0;
  endtask

  initial begin
    m_valid = 0; m_id = 0; m_tag = 0; m_r = 0; m_flags = 0; m_last = 1;
    m_cnt0 = 0; m_cnt1 = 0; m_s0 = 0; m_s1 = 0;
    test_reset();
    test_port0_only();
    test_contention();
    test_stall();
    test_back_to_back();
    test_reset_midflight();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
